// File: rtl/wb_regfile_sb.sv
// rtl/wb_regfile_sb.sv - writeback register file with per-register pending-write scoreboard
// Optional same-cycle writeback bypass to the read ports: define WB_BYPASS_EN.
module wb_regfile_sb #(
  parameter int NREGS = 16,
  parameter int DW    = 16,
  parameter int CNTW  = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wb_valid,
  input  logic [3:0]    wb_rd,
  input  logic [DW-1:0] wb_data,
  input  logic [3:0]    rs1,
  input  logic [3:0]    rs2,
  output logic [DW-1:0] rd1,
  output logic [DW-1:0] rd2,
  input  logic          iss_valid,
  input  logic [3:0]    iss_rd,
  output logic          iss_ready,
  output logic          rs1_busy,
  output logic          rs2_busy,
  output logic          stall,
  input  logic          flush
);

  localparam logic [CNTW-1:0] CNT_MAX  = '1;
  localparam logic [CNTW-1:0] CNT_ZERO = '0;
  localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);

  logic [DW-1:0]   regs [NREGS];
  logic [CNTW-1:0] cnt  [NREGS];
  logic [NREGS-1:0] inc;
  logic [NREGS-1:0] dec;

  logic          wb_hit1;
  logic          wb_hit2;
  logic [DW-1:0] reg_rd1;
  logic [DW-1:0] reg_rd2;
  logic [CNTW-1:0] cnt_rs1;
  logic [CNTW-1:0] cnt_rs2;

  // R0 is never written, so its storage stays at its reset value of zero.
  assign iss_ready = (cnt[iss_rd] != CNT_MAX) || (iss_rd == 4'd0);

  genvar g;
  generate
    for (g = 0; g < NREGS; g++) begin : g_sb
      if (g == 0) begin : g_r0
        assign inc[g] = 1'b0;
        assign dec[g] = 1'b0;
      end else begin : g_rn
        assign inc[g] = iss_valid && iss_ready && (iss_rd == 4'(g));
        assign dec[g] = wb_valid && (wb_rd == 4'(g)) && (cnt[g] != CNT_ZERO);
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
        cnt[i]  <= '0;
      end
    end else begin
      if (wb_valid && (wb_rd != 4'd0)) begin
        regs[wb_rd] <= wb_data;
      end
      // Flush drops every pending entry, including a same-cycle issue.
      for (int i = 0; i < NREGS; i++) begin
        if (flush) begin
          cnt[i] <= '0;
        end else if (inc[i] && !dec[i]) begin
          cnt[i] <= cnt[i] + CNT_ONE;
        end else if (dec[i] && !inc[i]) begin
          cnt[i] <= cnt[i] - CNT_ONE;
        end
      end
    end
  end

  assign reg_rd1 = (rs1 == 4'd0) ? '0 : regs[rs1];
  assign reg_rd2 = (rs2 == 4'd0) ? '0 : regs[rs2];
  assign cnt_rs1 = cnt[rs1];
  assign cnt_rs2 = cnt[rs2];
  assign wb_hit1 = wb_valid && (wb_rd == rs1) && (rs1 != 4'd0);
  assign wb_hit2 = wb_valid && (wb_rd == rs2) && (rs2 != 4'd0);

`ifdef WB_BYPASS_EN
  // The last outstanding write is landing now, so decode may proceed on bypassed data.
  assign rd1      = wb_hit1 ? wb_data : reg_rd1;
  assign rd2      = wb_hit2 ? wb_data : reg_rd2;
  assign rs1_busy = (cnt_rs1 != CNT_ZERO) && !(wb_hit1 && (cnt_rs1 == CNT_ONE));
  assign rs2_busy = (cnt_rs2 != CNT_ZERO) && !(wb_hit2 && (cnt_rs2 == CNT_ONE));
`else
  logic unused_hits;
  assign unused_hits = wb_hit1 ^ wb_hit2;
  assign rd1      = reg_rd1;
  assign rd2      = reg_rd2;
  assign rs1_busy = (cnt_rs1 != CNT_ZERO);
  assign rs2_busy = (cnt_rs2 != CNT_ZERO);
`endif

  assign stall = rs1_busy || rs2_busy || (iss_valid && !iss_ready);

endmodule
